// File: rtl/ldpc_pkg.sv
// Shared constants, FSM state type and frame bit-offset helper for the LDPC front end.
package ldpc_pkg;

  localparam int unsigned N       = 12;
  localparam int unsigned LLR_W   = 6;
  localparam int unsigned MAX_CYC = 32;
  localparam int unsigned CNT_W   = 6;
  localparam int unsigned BEAT_W  = $clog2(N);
  localparam int unsigned FRAME_W = N * LLR_W;
  localparam int unsigned OFF_W   = $clog2(FRAME_W);

  typedef enum logic [1:0] {
    StIdle,
    StLaunch,
    StWait,
    StResult
  } state_e;

  // LSB position of LLR k; the first LLR of a frame sits in the MSBs.
  function automatic int unsigned llr_lsb(input int unsigned k);
    return LLR_W * (N - 1 - k);
  endfunction

endpackage

// File: rtl/ldpc_frame_scheduler_if.sv
// LLR input stream and result stream of the LDPC frame scheduler.
interface ldpc_frame_scheduler_if;
  import ldpc_pkg::*;

  logic             llr_valid;
  logic             llr_ready;
  logic [LLR_W-1:0] llr_data;
  logic             llr_last;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_v_hat;
  logic             out_converged;
  logic [CNT_W-1:0] out_cycles;

  modport master (
    output llr_valid, llr_data, llr_last, out_ready,
    input  llr_ready, out_valid, out_v_hat, out_converged, out_cycles
  );

  modport slave (
    input  llr_valid, llr_data, llr_last, out_ready,
    output llr_ready, out_valid, out_v_hat, out_converged, out_cycles
  );

endinterface

// File: rtl/ldpc_llr_assembler.sv
// Collects N serial LLR beats into one frame, checks framing, and holds it until taken.
module ldpc_llr_assembler
  import ldpc_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               llr_valid_i,
  input  logic [LLR_W-1:0]   llr_data_i,
  input  logic               llr_last_i,
  output logic               llr_ready_o,
  input  logic               take_i,
  output logic               asm_full_o,
  output logic [FRAME_W-1:0] asm_data_o,
  output logic               frame_err_o
);

  localparam logic [BEAT_W-1:0] LastBeat = BEAT_W'(N - 1);

  logic [BEAT_W-1:0]  cnt_q, cnt_d;
  logic [FRAME_W-1:0] asm_q, asm_d;
  logic               full_q, full_d;
  logic               err_q, err_d;
  logic               rdy_q;
  logic               fire;
  logic               at_end;
  logic [OFF_W-1:0]   off;

  // rdy_q keeps llr_ready low until the first clock edge after reset release.
  assign llr_ready_o = rdy_q && !full_q;
  assign fire        = llr_valid_i && llr_ready_o;
  assign at_end      = (cnt_q == LastBeat);
  assign off         = OFF_W'(llr_lsb(32'(cnt_q)));
  assign asm_full_o  = full_q;
  assign asm_data_o  = asm_q;
  assign frame_err_o = err_q;

  always_comb begin
    cnt_d  = cnt_q;
    asm_d  = asm_q;
    full_d = full_q;
    err_d  = 1'b0;
    if (take_i) begin
      full_d = 1'b0;
    end
    if (fire) begin
      asm_d[off +: LLR_W] = llr_data_i;
      cnt_d = cnt_q + 1'b1;
      if (llr_last_i || at_end) begin
        cnt_d = '0;
        if (llr_last_i && at_end) begin
          full_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      asm_q  <= '0;
      full_q <= 1'b0;
      err_q  <= 1'b0;
      rdy_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      asm_q  <= asm_d;
      full_q <= full_d;
      err_q  <= err_d;
      rdy_q  <= 1'b1;
    end
  end

endmodule

// File: rtl/ldpc_frame_scheduler.sv
// Launches assembled frames into the LDPC decoder and returns hard decisions with a
// converged/timeout flag; assembly of the next frame overlaps decoding.
module ldpc_frame_scheduler
  import ldpc_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  ldpc_frame_scheduler_if.slave bus_io,
  output logic                 dec_lambda_valid_o,
  output logic [FRAME_W-1:0]   dec_lambda_o,
  input  logic [N-1:0]         dec_v_hat_i,
  input  logic                 dec_done_i,
  output logic                 frame_err_o,
  output logic                 busy_o
);

  state_e             state_q, state_d;
  logic [FRAME_W-1:0] lambda_q, lambda_d;
  logic [CNT_W-1:0]   cyc_q, cyc_d;
  logic [N-1:0]       vhat_q, vhat_d;
  logic               conv_q, conv_d;
  logic [CNT_W-1:0]   ocyc_q, ocyc_d;
  logic               take;
  logic               asm_full;
  logic [FRAME_W-1:0] asm_data;

  ldpc_llr_assembler u_asm (
    .clk         (clk),
    .rst         (rst),
    .llr_valid_i (bus_io.llr_valid),
    .llr_data_i  (bus_io.llr_data),
    .llr_last_i  (bus_io.llr_last),
    .llr_ready_o (bus_io.llr_ready),
    .take_i      (take),
    .asm_full_o  (asm_full),
    .asm_data_o  (asm_data),
    .frame_err_o (frame_err_o)
  );

  always_comb begin
    state_d  = state_q;
    lambda_d = lambda_q;
    cyc_d    = cyc_q;
    vhat_d   = vhat_q;
    conv_d   = conv_q;
    ocyc_d   = ocyc_q;
    take     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (asm_full) begin
          lambda_d = asm_data;
          take     = 1'b1;
          state_d  = StLaunch;
        end
      end
      StLaunch: begin
        cyc_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        cyc_d = cyc_q + 1'b1;
        // Counter 0 masks a done left over from the previous frame.
        if ((cyc_q != '0) && dec_done_i) begin
          vhat_d  = dec_v_hat_i;
          conv_d  = 1'b1;
          ocyc_d  = cyc_q;
          state_d = StResult;
        end else if (cyc_q == CNT_W'(MAX_CYC)) begin
          vhat_d  = dec_v_hat_i;
          conv_d  = 1'b0;
          ocyc_d  = CNT_W'(MAX_CYC);
          state_d = StResult;
        end
      end
      StResult: begin
        if (bus_io.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      lambda_q <= '0;
      cyc_q    <= '0;
      vhat_q   <= '0;
      conv_q   <= 1'b0;
      ocyc_q   <= '0;
    end else begin
      state_q  <= state_d;
      lambda_q <= lambda_d;
      cyc_q    <= cyc_d;
      vhat_q   <= vhat_d;
      conv_q   <= conv_d;
      ocyc_q   <= ocyc_d;
    end
  end

  assign dec_lambda_valid_o   = (state_q == StLaunch);
  assign dec_lambda_o         = lambda_q;
  assign busy_o               = (state_q == StLaunch) || (state_q == StWait);
  assign bus_io.out_valid     = (state_q == StResult);
  assign bus_io.out_v_hat     = vhat_q;
  assign bus_io.out_converged = conv_q;
  assign bus_io.out_cycles    = ocyc_q;

endmodule

// File: doc/ldpc_frame_scheduler.md
Name: ldpc_frame_scheduler

Overview:
Front-end controller for the 12-bit LDPC decoder (ldpc_decoder). Accepts channel LLRs serially, one 6-bit LLR per beat, over a valid/ready stream and assembles them into a 72-bit frame. It launches the decoder with a one-cycle lambda_valid pulse, then waits for done or an iteration timeout. The hard decision is returned on a valid/ready result port with a converged/timeout flag. Frame assembly is double-buffered, so the next frame can be collected while the current one decodes.

Parameters:
N, 12, codeword length (LLRs per frame)
LLR_W, 6, bits per LLR
MAX_CYC, 32, decode cycles allowed after launch before timeout
CNT_W, 6, width of cycle counter; must hold MAX_CYC

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
llr_valid  in  1  input LLR beat valid
llr_ready  out  1  scheduler can accept a beat
llr_data  in  LLR_W  LLR value, two's complement
llr_last  in  1  marks final LLR of a frame
dec_lambda_valid  out  1  one-cycle launch pulse to decoder
dec_lambda  out  N*LLR_W  frame to decoder; held stable from launch until result capture
dec_v_hat  in  N  decoder hard decision
dec_done  in  1  decoder converged
out_valid  out  1  result available
out_ready  in  1  downstream accepts result
out_v_hat  out  N  captured hard decision
out_converged  out  1  1 = done seen, 0 = timeout
out_cycles  out  CNT_W  cycles from launch to capture
frame_err  out  1  one-cycle pulse: framing error, frame dropped
busy  out  1  decoder occupied (LAUNCH or WAIT state)

Behaviour:
- Reset (async, rst=1): every output is 0, llr_ready=0. The beat counter, assembly-full flag, FSM and result register are cleared. Any partial or in-flight frame is discarded. Outputs are driven low in the first cycle after rst deasserts, except llr_ready, which rises on the first clk edge after release.
- Assembly:
  - A beat transfers when llr_valid && llr_ready.
  - Beat k (k=0 first) is written to assembly bits [LLR_W*(N-k)-1 : LLR_W*(N-k-1)], so the first LLR occupies the MSBs.
  - The beat counter runs 0..N-1.
  - llr_ready = !asm_full.
- Framing:
  - llr_last on beat k=N-1: asm_full is set.
  - llr_last on beat k<N-1: the frame is dropped, the counter clears and frame_err pulses.
  - Beat N-1 without llr_last: the frame is dropped and frame_err pulses.
  - asm_full is never set by an errored frame.
- FSM IDLE -> LAUNCH -> WAIT -> RESULT -> IDLE:
  - IDLE: when asm_full, copy the assembly register to the dec_lambda register, clear asm_full (llr_ready returns next cycle) and go to LAUNCH.
  - LAUNCH: dec_lambda_valid=1 for exactly this cycle. Clear the cycle counter and go to WAIT.
  - WAIT: the counter increments each cycle. dec_done is ignored while the counter is 0, so a stale done from the previous frame is masked. Once the counter is 1 or more:
    - dec_done=1: capture dec_v_hat, out_converged=1, out_cycles=counter, go to RESULT.
    - Otherwise, when the counter reaches MAX_CYC: capture dec_v_hat, out_converged=0, out_cycles=MAX_CYC, go to RESULT.
    - If dec_done coincides with the counter reaching MAX_CYC, converged wins.
  - RESULT: out_valid=1. The outputs hold stable until out_ready. On handshake, out_valid drops next cycle and the FSM goes to IDLE. If asm_full is already set, the IDLE copy happens in that IDLE cycle, so there is no extra bubble.
- Assembly continues in all FSM states. Backpressure through out_ready stalls only the launch, never partial collection.
- Simultaneous final beat and IDLE check: asm_full is registered, so launch occurs the cycle after the final beat.
- busy = (state==LAUNCH || state==WAIT).

Decomposition:
- Shared package ldpc_pkg holds N, LLR_W, the FSM state enum (IDLE, LAUNCH, WAIT, RESULT) and a frame-slice helper function for bit-offset computation.
- One sub-module, ldpc_llr_assembler, contains the beat counter, framing check, assembly register and asm_full handshake.
- The FSM and result register live in the top level.

Test Plan:
- Single frame: beats 111100, 010100, 101001, 001110, 111010, 111111, 110101, 001010, 010000, 001010, 101111, 001100, llr_last on the 12th; model decoder returns done 3 cycles after launch with v_hat=12'hA5C -> dec_lambda equals those 12 beats concatenated MSB-first, dec_lambda_valid pulses once, out_v_hat=12'hA5C, out_converged=1, out_cycles=3.
- Timeout: decoder never asserts done, v_hat=12'h0F0 -> out_valid after MAX_CYC=32 cycles in WAIT, out_converged=0, out_cycles=32.
- Framing error: llr_last on beat 5 -> frame_err pulse, no dec_lambda_valid; the next correct 12-beat frame decodes normally.
- Back-to-back with backpressure: two frames streamed continuously, out_ready held 0 for 10 cycles -> frame 2 fully collected, llr_ready=0 while asm_full, out_v_hat stable; after out_ready, frame 2 launches within 2 cycles.
- Stale done: dec_done held high through launch, dropped at the counter-0 cycle, reasserted at counter 4 -> out_cycles=4.
- Reset mid-WAIT: rst asserted at counter 7 -> all outputs 0 immediately; after release llr_ready=1 and a fresh frame decodes correctly.
